// File: rtl/bus_pkg.sv
// Shared definitions for the multiplexed address/data bus initiator.
// Holds the initiator FSM state type, bus constants and the latched request payload.
package bus_pkg;

  localparam int unsigned BUS_DATA_W          = 32;
  localparam int unsigned BUS_BE_W            = 4;
  localparam int unsigned BUS_BURST_W         = 8;
  localparam int unsigned BUS_TIMEOUT_CNT_W   = 16;
  localparam int unsigned BUS_TIMEOUT_DEFAULT = 255;

  localparam logic [BUS_BURST_W-1:0] BUS_BURST_SINGLE = 8'd0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    BEGIN = 3'd2,
    DATA  = 3'd3,
    RESP  = 3'd4
  } bus_init_state_t;

  // Request captured at acceptance and held for the whole transaction
  typedef struct packed {
    logic                  write;
    logic [BUS_DATA_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
    logic [BUS_BE_W-1:0]   be;
  } bus_req_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// DATA-phase watchdog for the bus initiator.
// Ports: clk, rst_n (async active-low), enable (count one stalled DATA cycle),
//        clear (restart from zero), expired (count has reached LIMIT).
module bus_timeout_counter
  import bus_pkg::*;
#(
  parameter int unsigned WIDTH = BUS_TIMEOUT_CNT_W,
  parameter int unsigned LIMIT = BUS_TIMEOUT_DEFAULT - 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  logic [WIDTH-1:0] count;

  // Saturates at LIMIT so a lingering enable cannot wrap the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + WIDTH'(1);
    end
  end

  assign expired = (count == WIDTH'(LIMIT));

endmodule

// File: rtl/bus_initiator.sv
// Single-beat initiator for the shared multiplexed address/data bus.
// Accepts one local read/write request, arbitrates, issues the address phase,
// then drives write data or collects read data and returns a one-cycle response.
// Ports: req_* local request side, resp_* response strobe, bus_* shared bus side.
// All bus and response outputs decode only the state register and latched data.
// Optional DATA-phase timeout: define BUS_INITIATOR_TIMEOUT_EN.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_write_i,
  input  logic [BUS_DATA_W-1:0]  req_addr_i,
  input  logic [BUS_DATA_W-1:0]  req_wdata_i,
  input  logic [BUS_BE_W-1:0]    req_be_i,
  output logic                   resp_valid_o,
  output logic [BUS_DATA_W-1:0]  resp_rdata_o,
  output logic                   resp_error_o,
  output logic                   bus_request_o,
  input  logic                   bus_grant_i,
  output logic [BUS_DATA_W-1:0]  bus_addrData_o,
  output logic [BUS_BE_W-1:0]    bus_byteEnables_o,
  output logic [BUS_BURST_W-1:0] bus_burstSize_o,
  output logic                   bus_readNWrite_o,
  output logic                   bus_beginTransaction_o,
  output logic                   bus_endTransaction_o,
  output logic                   bus_dataValid_o,
  input  logic [BUS_DATA_W-1:0]  bus_addrData_i,
  input  logic                   bus_endTransaction_i,
  input  logic                   bus_dataValid_i,
  input  logic                   bus_busy_i,
  input  logic                   bus_error_i
);

  bus_init_state_t       state, state_nxt;
  bus_req_t              req_q;
  logic [BUS_DATA_W-1:0] rdata_q;
  logic                  error_q;
  logic                  done_c;
  logic                  expired;

  // A stalled end (busy high) does not complete the beat
  assign done_c = bus_endTransaction_i && !bus_busy_i;

`ifdef BUS_INITIATOR_TIMEOUT_EN
  // Cleared in BEGIN so the count is zero on the first DATA cycle
  bus_timeout_counter #(
    .WIDTH (BUS_TIMEOUT_CNT_W),
    .LIMIT (TIMEOUT_CYCLES - 1)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  ((state == DATA) && !done_c),
    .clear   (state == BEGIN),
    .expired (expired)
  );
`else
  // Without the watchdog DATA waits indefinitely; the parameter has no effect
  assign expired = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt              = state;
    req_ready_o            = 1'b0;
    resp_valid_o           = 1'b0;
    resp_rdata_o           = '0;
    resp_error_o           = 1'b0;
    bus_request_o          = 1'b0;
    bus_addrData_o         = '0;
    bus_byteEnables_o      = '0;
    bus_burstSize_o        = BUS_BURST_SINGLE;
    bus_readNWrite_o       = 1'b1;
    bus_beginTransaction_o = 1'b0;
    bus_endTransaction_o   = 1'b0;
    bus_dataValid_o        = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_nxt = REQ;
      end
      REQ: begin
        bus_request_o = 1'b1;
        if (bus_grant_i) state_nxt = BEGIN;
      end
      BEGIN: begin
        bus_request_o          = 1'b1;
        bus_beginTransaction_o = 1'b1;
        bus_addrData_o         = req_q.addr;
        bus_byteEnables_o      = req_q.be;
        bus_readNWrite_o       = ~req_q.write;
        state_nxt              = DATA;
      end
      DATA: begin
        bus_request_o     = 1'b1;
        bus_byteEnables_o = req_q.be;
        bus_readNWrite_o  = ~req_q.write;
        if (req_q.write) begin
          bus_addrData_o       = req_q.wdata;
          bus_dataValid_o      = 1'b1;
          bus_endTransaction_o = 1'b1;
        end
        if (done_c || expired) state_nxt = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        resp_rdata_o = rdata_q;
        resp_error_o = error_q;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and response capture; completion takes priority over expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (state == IDLE && req_valid_i) begin
        req_q <= '{write: req_write_i, addr: req_addr_i, wdata: req_wdata_i, be: req_be_i};
      end
      if (state == DATA) begin
        if (done_c) begin
          // A read that ends without valid data is reported as an error
          error_q <= bus_error_i || (!req_q.write && !bus_dataValid_i);
          rdata_q <= (!req_q.write && !bus_error_i && bus_dataValid_i) ? bus_addrData_i : '0;
        end else if (expired) begin
          error_q <= 1'b1;
          rdata_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: directed and randomized single-beat
// transactions against a timeline/result model, plus an asynchronous reset abort.
// Build with BUS_INITIATOR_TIMEOUT_EN defined to exercise the watchdog.
module tb_bus_initiator;

  localparam int unsigned TO_CYC = 4;
`ifdef BUS_INITIATOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_be_i;
  logic        resp_valid_o, resp_error_o;
  logic [31:0] resp_rdata_o;
  logic        bus_request_o, bus_grant_i;
  logic [31:0] bus_addrData_o;
  logic [3:0]  bus_byteEnables_o;
  logic [7:0]  bus_burstSize_o;
  logic        bus_readNWrite_o, bus_beginTransaction_o, bus_endTransaction_o, bus_dataValid_o;
  logic [31:0] bus_addrData_i;
  logic        bus_endTransaction_i, bus_dataValid_i, bus_busy_i, bus_error_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_initiator #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .req_valid_i            (req_valid_i),
    .req_ready_o            (req_ready_o),
    .req_write_i            (req_write_i),
    .req_addr_i             (req_addr_i),
    .req_wdata_i            (req_wdata_i),
    .req_be_i               (req_be_i),
    .resp_valid_o           (resp_valid_o),
    .resp_rdata_o           (resp_rdata_o),
    .resp_error_o           (resp_error_o),
    .bus_request_o          (bus_request_o),
    .bus_grant_i            (bus_grant_i),
    .bus_addrData_o         (bus_addrData_o),
    .bus_byteEnables_o      (bus_byteEnables_o),
    .bus_burstSize_o        (bus_burstSize_o),
    .bus_readNWrite_o       (bus_readNWrite_o),
    .bus_beginTransaction_o (bus_beginTransaction_o),
    .bus_endTransaction_o   (bus_endTransaction_o),
    .bus_dataValid_o        (bus_dataValid_o),
    .bus_addrData_i         (bus_addrData_i),
    .bus_endTransaction_i   (bus_endTransaction_i),
    .bus_dataValid_i        (bus_dataValid_i),
    .bus_busy_i             (bus_busy_i),
    .bus_error_i            (bus_error_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic quiet_inputs();
    req_valid_i          = 1'b0;
    req_write_i          = 1'b0;
    req_addr_i           = '0;
    req_wdata_i          = '0;
    req_be_i             = '0;
    bus_grant_i          = 1'b0;
    bus_addrData_i       = '0;
    bus_endTransaction_i = 1'b0;
    bus_dataValid_i      = 1'b0;
    bus_busy_i           = 1'b0;
    bus_error_i          = 1'b0;
  endtask

  // Entered and left at #1 after a rising edge.  g = grant-low REQ cycles,
  // n = DATA cycles with no end, m = DATA cycles with end but busy.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int g, input int n, input int m,
                         input bit s_err, input bit s_dv, input logic [31:0] s_rdata);
    int          t_beg, t_resp;
    bit          timed_out, in_end, exp_err;
    logic [31:0] exp_rdata;
    t_beg     = 2 + g;
    timed_out = TO_EN && ((n + m) > int'(TO_CYC) - 1);
    t_resp    = timed_out ? (t_beg + 1 + int'(TO_CYC)) : (t_beg + 1 + n + m + 1);
    if (timed_out) begin
      exp_err = 1'b1;
    end else if (wr) begin
      exp_err = s_err;
    end else begin
      exp_err = s_err || !s_dv;
    end
    exp_rdata = (wr || exp_err) ? 32'h0 : s_rdata;

    for (int t = 0; t <= t_resp; t++) begin
      req_valid_i = (t == 0);
      req_write_i = (t == 0) ? wr    : 1'($urandom);
      req_addr_i  = (t == 0) ? addr  : $urandom;
      req_wdata_i = (t == 0) ? wdata : $urandom;
      req_be_i    = (t == 0) ? be    : 4'($urandom);
      bus_grant_i = (t >= 1 + g);
      in_end      = (t >= t_beg + 1 + n);
      bus_endTransaction_i = in_end;
      bus_busy_i           = in_end ? (t < t_beg + 1 + n + m) : 1'($urandom);
      bus_dataValid_i      = in_end && !wr && s_dv;
      bus_error_i          = in_end && s_err;
      bus_addrData_i       = (in_end && !wr) ? s_rdata : $urandom;

      @(negedge clk);
      check($sformatf("ready t%0d", t), 32'(req_ready_o), 32'(t == 0));
      check($sformatf("request t%0d", t), 32'(bus_request_o), 32'(t >= 1 && t < t_resp));
      check($sformatf("begin t%0d", t), 32'(bus_beginTransaction_o), 32'(t == t_beg));
      check($sformatf("resp_valid t%0d", t), 32'(resp_valid_o), 32'(t == t_resp));
      check($sformatf("rnw t%0d", t), 32'(bus_readNWrite_o),
            32'((t >= t_beg && t < t_resp) ? !wr : 1'b1));
      if (t == t_beg) begin
        check("begin addr", bus_addrData_o, addr);
        check("begin be", 32'(bus_byteEnables_o), 32'(be));
        check("burst", 32'(bus_burstSize_o), 32'h0);
      end else if (t > t_beg && t < t_resp) begin
        check($sformatf("data addrData t%0d", t), bus_addrData_o, wr ? wdata : 32'h0);
        check($sformatf("data dv t%0d", t), 32'(bus_dataValid_o), 32'(wr));
        check($sformatf("data end t%0d", t), 32'(bus_endTransaction_o), 32'(wr));
        check($sformatf("data be t%0d", t), 32'(bus_byteEnables_o), 32'(be));
      end else begin
        check($sformatf("idle addrData t%0d", t), bus_addrData_o, 32'h0);
      end
      if (t == t_resp) begin
        check("resp rdata", resp_rdata_o, exp_rdata);
        check("resp error", 32'(resp_error_o), 32'(exp_err));
      end else begin
        check($sformatf("rdata idle t%0d", t), resp_rdata_o, 32'h0);
      end
      @(posedge clk);
      #1;
    end
    quiet_inputs();
  endtask

  initial begin
    quiet_inputs();
    rst_n = 1'b0;
    #12;
    check("rst ready", 32'(req_ready_o), 32'h1);
    check("rst rnw", 32'(bus_readNWrite_o), 32'h1);
    check("rst request", 32'(bus_request_o), 32'h0);
    check("rst resp_valid", 32'(resp_valid_o), 32'h0);
    check("rst addrData", bus_addrData_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    run_txn(1'b1, 32'h00F0_0004, 32'h0000_01B2, 4'hF, 0, 0, 0, 1'b0, 1'b1, 32'h0);
    run_txn(1'b0, 32'h00F0_0008, 32'h0, 4'hF, 0, 0, 0, 1'b0, 1'b1, 32'h0000_0083);
    run_txn(1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'h3, 3, 0, 2, 1'b0, 1'b1, 32'h0);
    run_txn(1'b0, 32'h0000_2000, 32'h0, 4'hF, 0, 0, 0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    run_txn(1'b0, 32'h0000_3000, 32'h0, 4'hF, 1, 1, 0, 1'b0, 1'b0, 32'h1234_5678);
    run_txn(1'b0, 32'h0000_4000, 32'h0, 4'hC, 0, 0, 3, 1'b0, 1'b1, 32'h0BAD_CAFE);
    if (TO_EN) begin
      run_txn(1'b0, 32'h0000_5000, 32'h0, 4'hF, 0, 20, 0, 1'b0, 1'b1, 32'h5555_AAAA);
      run_txn(1'b1, 32'h0000_6000, 32'h7777_8888, 4'hF, 2, 1, 3, 1'b0, 1'b1, 32'h0);
    end

    // Asynchronous reset in the DATA phase of a write
    req_valid_i = 1'b1; req_write_i = 1'b1;
    req_addr_i = 32'h0000_7000; req_wdata_i = 32'h1111_2222; req_be_i = 4'hF;
    bus_grant_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
    end
    @(negedge clk);
    check("pre-rst data dv", 32'(bus_dataValid_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort dv", 32'(bus_dataValid_o), 32'h0);
    check("abort end", 32'(bus_endTransaction_o), 32'h0);
    check("abort begin", 32'(bus_beginTransaction_o), 32'h0);
    check("abort request", 32'(bus_request_o), 32'h0);
    check("abort addrData", bus_addrData_o, 32'h0);
    check("abort ready", 32'(req_ready_o), 32'h1);
    check("abort rnw", 32'(bus_readNWrite_o), 32'h1);
    quiet_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check($sformatf("no resp after abort %0d", t), 32'(resp_valid_o), 32'h0);
    end
    @(posedge clk);
    #1;
    run_txn(1'b0, 32'h0000_8000, 32'h0, 4'hF, 0, 0, 0, 1'b0, 1'b1, 32'h0000_00A5);

    // Randomized back-to-back transactions
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) != 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
